// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [PC_W-1:0] PC_INC      = 16'd2;
    localparam logic [4:0]      HALT_OPCODE = 5'b00000;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_STALL,
        S_DRAIN,
        S_HALTED
    } fetch_state_e;

    // Sequential fetch address; wraps FFFE -> 0000.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of {PC, instruction} pairs presented to decode.
// Head entry drives the decode outputs directly from registers.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [PC_W-1:0]          push_pc_i,
    input  logic [INSTR_W-1:0]       push_instr_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     valid_o,
    output logic [PC_W-1:0]          pc_o,
    output logic [PC_W-1:0]          next_pc_o,
    output logic [INSTR_W-1:0]       instr_o
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                pc_q[wr_q]    <= push_pc_i;
                instr_q[wr_q] <= push_instr_i;
                wr_q          <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign count_o   = cnt_q;
    assign valid_o   = (cnt_q != '0);
    assign pc_o      = pc_q[rd_q];
    assign instr_o   = instr_q[rd_q];
    assign next_pc_o = pc_next(pc_q[rd_q]);

endmodule

// File: rtl/fetch_stream.sv
// Instruction-fetch front end: one outstanding memory request at a time,
// responses buffered for decode, redirects flush and drain stale data.
// Optional feature macro: FETCH_HALT_STOP_EN (stop fetching after a HALT word).
module fetch_stream
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_rdy,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    PC_out,
    output logic [PC_W-1:0]    next_PC_out,
    output logic               halted,
    output logic               err
);

    localparam int            CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    // Set by reset: a response from a request issued before reset may still
    // arrive; the first one seen before any new accept is discarded silently.
    logic            ign_q, ign_d;

    logic [CW-1:0]   count, count_nxt;
    logic            accept, push, pop, rv_live, is_halt;

    assign mem_req  = (state_q == S_REQ) && !rst;
    assign mem_addr = pc_q;
    assign accept   = mem_req && mem_rdy;
    assign rv_live  = mem_rvalid && !ign_q;

    // Redirect beats both push and pop.
    assign push      = (state_q == S_WAIT) && mem_rvalid && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign count_nxt = count + CW'(push) - CW'(pop);

`ifdef FETCH_HALT_STOP_EN
    assign is_halt = (mem_rdata[15:11] == HALT_OPCODE);
    assign halted  = (state_q == S_HALTED);
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // Next state, fetch PC, sticky error and stale-response filter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        ign_d   = ign_q;
        if (mem_rvalid || accept) ign_d = 1'b0;
        if (rv_live && (state_q inside {S_REQ, S_STALL, S_HALTED})) err_d = 1'b1;
        if (redirect_valid) begin
            pc_d = {redirect_pc[PC_W-1:1], 1'b0};
            if (redirect_pc[0]) err_d = 1'b1;
            // Anything still in flight (including a request accepted this
            // very cycle) must be drained before the next request goes out.
            if (((state_q == S_WAIT) || (state_q == S_DRAIN) || accept) && !mem_rvalid)
                state_d = S_DRAIN;
            else
                state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ:   if (accept) state_d = S_WAIT;
                S_WAIT: begin
                    if (mem_rvalid) begin
                        pc_d = pc_next(pc_q);
                        if (is_halt)                    state_d = S_HALTED;
                        else if (count_nxt < DEPTH_C)   state_d = S_REQ;
                        else                            state_d = S_STALL;
                    end
                end
                S_STALL: if (count_nxt < DEPTH_C) state_d = S_REQ;
                S_DRAIN: if (mem_rvalid) state_d = S_REQ;
                S_HALTED: state_d = S_HALTED;
                default: state_d = S_REQ;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            ign_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            ign_q   <= ign_d;
        end
    end

    assign err = err_q;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .push_pc_i    (pc_q),
        .push_instr_i (mem_rdata),
        .count_o      (count),
        .valid_o      (inst_valid),
        .pc_o         (PC_out),
        .next_pc_o    (next_PC_out),
        .instr_o      (instruction)
    );

endmodule

// File: tb/tb_fetch_stream.sv
// Directed + randomized bench for fetch_stream. A memory model with
// configurable latency/readiness answers requests; a scoreboard expects decode
// to see consecutive even PCs from the last reset/redirect target, each paired
// with that address's memory word.
module tb_fetch_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rdy;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] instruction;
    logic [15:0] PC_out;
    logic [15:0] next_PC_out;
    logic        halted;
    logic        err;

    always #5 clk = ~clk;

    fetch_stream #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .PC_out(PC_out), .next_PC_out(next_PC_out),
        .halted(halted), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // memory model state
    logic [15:0] pq_addr[$];
    int          pq_due[$];
    int          cyc = 0;
    int          lat = 0;
    int          rdy_mode = 1;   // 0: never ready, 1: always, 2: random
    int          n_acc = 0;
    logic [15:0] last_acc = '0;
    logic        halt_word_en = 1'b0;

    // reference model state
    logic [15:0] exp_pc = 16'h0000;
    logic        exp_err = 1'b0;
    logic        chk_err_en = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'hC001;
        if (halt_word_en && a == 16'h0006) return 16'h0000;
        return {a[7:0] ^ 8'h5A, a[15:8]} | 16'h0800;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: caller has set rst/redirect/inst_ready at the negedge.
    task automatic tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pq_addr[0]);
            void'(pq_due.pop_front());
            void'(pq_addr.pop_front());
        end
        mem_rdy = (rdy_mode == 1) ? 1'b1 :
                  (rdy_mode == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
        #1;
        if (chk_err_en) chk("err", err, exp_err);
        if (mem_req && mem_rdy) begin
            chk("one_outstanding", pq_due.size(), 0);
            chk("addr_align", mem_addr[0], 0);
            pq_addr.push_back(mem_addr);
            pq_due.push_back(cyc + 1 + lat);
            n_acc++;
            last_acc = mem_addr;
        end
        if (rst) begin
            exp_pc  = 16'h0000;
            exp_err = 1'b0;
        end else if (redirect_valid) begin
            exp_pc = {redirect_pc[15:1], 1'b0};
            if (redirect_pc[0]) exp_err = 1'b1;
        end else if (inst_valid && inst_ready) begin
            chk("pop_pc", PC_out, exp_pc);
            chk("pop_instr", instruction, mem_word(exp_pc));
            chk("pop_next_pc", next_PC_out, 16'(exp_pc + 16'd2));
            exp_pc = exp_pc + 16'd2;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input int maxc);
        int n0;
        int k;
        n0 = n_acc;
        k  = 0;
        while (n_acc == n0 && k < maxc) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, (n_acc != n0), 1);
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k;
        k = 0;
        while (!inst_valid && k < maxc) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, inst_valid, 1);
    endtask

    initial begin
        int n0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        mem_rdy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // reset state
        @(negedge clk);
        tick();
        chk_err_en = 1'b1;
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_halted", halted, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_pc_out", PC_out, 0);
        rst = 1'b0;
        #1;
        chk("first_mem_req", mem_req, 1);
        chk("first_mem_addr", mem_addr, 16'h0000);

        // first word, 1-cycle memory
        wait_valid("first_valid", 10);
        chk("first_instr", instruction, 16'hC001);
        chk("first_pc", PC_out, 16'h0000);
        chk("first_next_pc", next_PC_out, 16'h0002);

        // decode stalled: buffer fills to two entries, no further requests
        repeat (8) tick();
        chk("stall_acc_count", n_acc, 2);
        chk("stall_mem_req", mem_req, 0);
        chk("stall_head_pc", PC_out, 16'h0000);
        chk("stall_valid", inst_valid, 1);

        // release decode: in-order pops, then request at 0004 (slow response)
        inst_ready = 1'b1;
        lat = 2;
        wait_acc("acc_0004", 10);
        chk("acc_0004_addr", last_acc, 16'h0004);

        // redirect while waiting: stale response dropped
        redirect(16'h0100);
        chk("redir_flush_valid", inst_valid, 0);
        wait_acc("acc_0100", 10);
        chk("acc_0100_addr", last_acc, 16'h0100);
        lat = 0;
        wait_valid("valid_0100", 10);
        chk("valid_0100_pc", PC_out, 16'h0100);

        // misaligned redirect: aligned fetch, sticky err
        redirect(16'h0041);
        chk("odd_redir_err", err, 1);
        wait_acc("acc_0040", 12);
        chk("acc_0040_addr", last_acc, 16'h0040);
        repeat (4) tick();
        chk("err_sticky", err, 1);

        // wrap at top of address space
        inst_ready = 1'b0;
        redirect(16'hFFFE);
        wait_valid("valid_fffe", 12);
        chk("wrap_pc", PC_out, 16'hFFFE);
        chk("wrap_next_pc", next_PC_out, 16'h0000);
        chk("wrap_instr", instruction, mem_word(16'hFFFE));
        wait_acc("acc_wrap", 10);
        chk("wrap_acc_addr", last_acc, 16'h0000);
        inst_ready = 1'b1;
        repeat (6) tick();

        // reset with a request outstanding: late response must be ignored
        lat = 3;
        wait_acc("acc_pre_rst", 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy_mode = 0;
        repeat (6) tick();
        chk("stale_err", err, 0);
        chk("stale_valid", inst_valid, 0);
        chk("stale_mem_req", mem_req, 1);
        rdy_mode = 1;
        lat = 0;
        wait_acc("acc_post_rst", 10);
        chk("post_rst_addr", last_acc, 16'h0000);
        wait_valid("valid_post_rst", 10);
        chk("post_rst_pc", PC_out, 16'h0000);

        // randomized traffic
        rdy_mode = 2;
        repeat (400) begin
            lat = $urandom_range(0, 3);
            inst_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 16'($urandom);
            end
            tick();
            redirect_valid = 1'b0;
        end
        chk("rand_halted", halted, 0);

        // HALT word at 0006
        halt_word_en = 1'b1;
        rdy_mode = 1;
        lat = 0;
        inst_ready = 1'b1;
        redirect(16'h0006);
        wait_valid("valid_halt", 12);
        chk("halt_instr", instruction, 16'h0000);
        chk("halt_pc", PC_out, 16'h0006);
`ifdef FETCH_HALT_STOP_EN
        repeat (2) tick();
        chk("halted_set", halted, 1);
        n0 = n_acc;
        repeat (6) tick();
        chk("halted_no_req", n_acc - n0, 0);
        chk("halted_mem_req", mem_req, 0);
        redirect(16'h0020);
        chk("halted_clear", halted, 0);
        wait_acc("acc_resume", 10);
        chk("resume_addr", last_acc, 16'h0020);
`else
        n0 = n_acc;
        wait_acc("acc_after_halt", 10);
        chk("after_halt_addr", last_acc, 16'h0008);
        chk("no_halt_flag", halted, 0);
        chk("after_halt_acc_count", n_acc - n0, 1);
`endif
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
